// File: rtl/ix_sb_pkg.sv
// Shared constants for the issue-stage register scoreboard: pipe IDs and the zero register.
package ix_sb_pkg;
  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         SB_PIPE_INT = 0;
  localparam int         SB_PIPE_LSP = 1;
endpackage

// File: rtl/ix_sb_lookup.sv
// Per-port scoreboard lookup: readiness and forwarding source for one architectural register.
// With IX_SB_BYPASS_EN a tag-matching writeback in the same cycle makes the register ready.
module ix_sb_lookup
  import ix_sb_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int NPIPE  = 2,
  parameter int PIPE_W = 1
) (
  input  logic [4:0]              chk_reg,
  input  logic [NREGS-1:0]        pend,
  input  logic [NREGS*PIPE_W-1:0] tag,
  input  logic [NPIPE-1:0]        wb_valid,
  input  logic [NPIPE*5-1:0]      wb_dst,
  output logic                    ready,
  output logic                    fwd_valid,
  output logic [PIPE_W-1:0]       fwd_pipe
);
  localparam int RW = $clog2(NREGS);

  logic busy;
  assign busy = (chk_reg != REG_ZERO) && pend[chk_reg[RW-1:0]];

`ifdef IX_SB_BYPASS_EN
  logic [PIPE_W-1:0] cur_tag;
  assign cur_tag = tag[chk_reg[RW-1:0]*PIPE_W +: PIPE_W];

  // Lowest-numbered pipe wins when several ports write back the same register.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_pipe  = '0;
    for (int p = NPIPE - 1; p >= 0; p--) begin
      if (busy && wb_valid[p] && wb_dst[p*5 +: 5] == chk_reg && cur_tag == PIPE_W'(p)) begin
        fwd_valid = 1'b1;
        fwd_pipe  = PIPE_W'(p);
      end
    end
  end

  assign ready = !busy || fwd_valid;
`else
  logic unused_wb;
  assign unused_wb = ^{tag, wb_valid, wb_dst};
  assign ready     = !busy;
  assign fwd_valid = 1'b0;
  assign fwd_pipe  = '0;
`endif
endmodule

// File: rtl/ix_scoreboard.sv
// Issue-stage register scoreboard: one pending writer per register, tagged by producing pipe.
// Optional same-cycle writeback bypass on readiness is enabled by defining IX_SB_BYPASS_EN.
module ix_scoreboard
  import ix_sb_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int NRS    = 2,
  parameter int NPIPE  = 2,
  parameter int PIPE_W = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRS*5-1:0]        chk_rs,
  input  logic [4:0]              chk_rd,
  input  logic                    chk_wb_en,
  output logic [NRS-1:0]          rs_ready,
  output logic [NRS-1:0]          rs_fwd_valid,
  output logic [NRS*PIPE_W-1:0]   rs_fwd_pipe,
  output logic                    rd_ready,
  input  logic                    iss_valid,
  input  logic                    iss_wb_en,
  input  logic [4:0]              iss_rd,
  input  logic [PIPE_W-1:0]       iss_pipe,
  input  logic [NPIPE-1:0]        wb_valid,
  input  logic [NPIPE*5-1:0]      wb_dst,
  input  logic [NPIPE-1:0]        kill,
  output logic                    idle,
  output logic                    err
);
  localparam int RW = $clog2(NREGS);

  logic [NREGS-1:0]        pend;
  logic [NREGS*PIPE_W-1:0] tag;
  logic [NREGS-1:0]        pend_n;
  logic [NREGS*PIPE_W-1:0] tag_n;
  logic                    err_n;
  logic [RW-1:0]           wdst;
  logic [RW-1:0]           idst;

  always_comb begin
    pend_n = pend;
    tag_n  = tag;
    err_n  = err;
    wdst   = '0;
    idst   = iss_rd[RW-1:0];
    for (int r = 0; r < NREGS; r++) begin
      for (int p = 0; p < NPIPE; p++) begin
        if (kill[p] && pend[r] && tag[r*PIPE_W +: PIPE_W] == PIPE_W'(p)) pend_n[r] = 1'b0;
      end
    end
    // Writebacks are judged against registered state; a killed matching writeback is not an error.
    for (int p = 0; p < NPIPE; p++) begin
      if (wb_valid[p] && wb_dst[p*5 +: 5] != REG_ZERO) begin
        wdst = wb_dst[p*5 +: RW];
        if (pend[wdst] && tag[wdst*PIPE_W +: PIPE_W] == PIPE_W'(p)) pend_n[wdst] = 1'b0;
        else err_n = 1'b1;
      end
    end
    // Issue wins over a same-cycle clear; overwriting a still-live entry is a caller error.
    if (iss_valid && iss_wb_en && iss_rd != REG_ZERO) begin
      if (pend_n[idst]) err_n = 1'b1;
      pend_n[idst]                    = 1'b1;
      tag_n[idst*PIPE_W +: PIPE_W]    = iss_pipe;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      tag  <= '0;
      err  <= 1'b0;
    end else begin
      pend <= pend_n;
      tag  <= tag_n;
      err  <= err_n;
    end
  end

  assign idle = ~|pend;

  for (genvar k = 0; k < NRS; k++) begin : g_rs
    ix_sb_lookup #(.NREGS(NREGS), .NPIPE(NPIPE), .PIPE_W(PIPE_W)) u_lookup (
      .chk_reg   (chk_rs[k*5 +: 5]),
      .pend      (pend),
      .tag       (tag),
      .wb_valid  (wb_valid),
      .wb_dst    (wb_dst),
      .ready     (rs_ready[k]),
      .fwd_valid (rs_fwd_valid[k]),
      .fwd_pipe  (rs_fwd_pipe[k*PIPE_W +: PIPE_W])
    );
  end

  logic              rd_free;
  logic              rd_fwd_valid;
  logic [PIPE_W-1:0] rd_fwd_pipe;
  logic              unused_rd;

  ix_sb_lookup #(.NREGS(NREGS), .NPIPE(NPIPE), .PIPE_W(PIPE_W)) u_rd_lookup (
    .chk_reg   (chk_rd),
    .pend      (pend),
    .tag       (tag),
    .wb_valid  (wb_valid),
    .wb_dst    (wb_dst),
    .ready     (rd_free),
    .fwd_valid (rd_fwd_valid),
    .fwd_pipe  (rd_fwd_pipe)
  );

  assign unused_rd = ^{rd_fwd_valid, rd_fwd_pipe};
  assign rd_ready  = !chk_wb_en || rd_free;
endmodule

// File: tb/tb_ix_scoreboard.sv
// Directed bench for ix_scoreboard: stimulus queues expected outputs, a monitor pops and checks.
module tb_ix_scoreboard;
  import ix_sb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] chk_rs;
  logic [4:0] chk_rd;
  logic       chk_wb_en;
  logic [1:0] rs_ready;
  logic [1:0] rs_fwd_valid;
  logic [1:0] rs_fwd_pipe;
  logic       rd_ready;
  logic       iss_valid;
  logic       iss_wb_en;
  logic [4:0] iss_rd;
  logic [0:0] iss_pipe;
  logic [1:0] wb_valid;
  logic [9:0] wb_dst;
  logic [1:0] kill;
  logic       idle;
  logic       err;

  ix_scoreboard #(.NREGS(32), .NRS(2), .NPIPE(2), .PIPE_W(1)) dut (
    .clk(clk), .rst(rst), .chk_rs(chk_rs), .chk_rd(chk_rd), .chk_wb_en(chk_wb_en),
    .rs_ready(rs_ready), .rs_fwd_valid(rs_fwd_valid), .rs_fwd_pipe(rs_fwd_pipe),
    .rd_ready(rd_ready), .iss_valid(iss_valid), .iss_wb_en(iss_wb_en), .iss_rd(iss_rd),
    .iss_pipe(iss_pipe), .wb_valid(wb_valid), .wb_dst(wb_dst), .kill(kill),
    .idle(idle), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [8:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Field order: rs_ready[1:0], rs_fwd_valid[1:0], rs_fwd_pipe[1:0], rd_ready, idle, err
  function automatic logic [8:0] pk(logic [1:0] rr, logic [1:0] fv, logic [1:0] fp,
                                    logic rd, logic idl, logic er);
    return {rr, fv, fp, rd, idl, er};
  endfunction

  task automatic expect_out(string nm, logic [8:0] v);
    exp_t e;
    e.name = nm;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    iss_valid = 1'b0; iss_wb_en = 1'b0; iss_rd = 5'd0; iss_pipe = 1'b0;
    wb_valid  = 2'b00; wb_dst = 10'd0; kill = 2'b00;
  endtask

  task automatic iss(input logic [4:0] rd, input int pipe);
    iss_valid = 1'b1; iss_wb_en = 1'b1; iss_rd = rd; iss_pipe = 1'(pipe);
  endtask

  task automatic chk(input logic [4:0] rs1, input logic [4:0] rs0,
                     input logic [4:0] rd, input logic wben);
    chk_rs = {rs1, rs0}; chk_rd = rd; chk_wb_en = wben;
  endtask

  initial begin : monitor
    logic [8:0] act;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {rs_ready, rs_fwd_valid, rs_fwd_pipe, rd_ready, idle, err};
        n_chk++;
        if (act !== e.val) begin
          n_fail++;
          $display("FAIL %s: got %b required %b (rr fv fp rd idle err)", e.name, act, e.val);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1;
    clr();
    chk(5'd0, 5'd0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expect_out("reset", pk(2'b11, 2'b00, 2'b00, 1, 1, 0));

    // 1: RAW/WAW after issue
    step(); iss(5'd5, SB_PIPE_INT);
    step(); clr(); chk(5'd0, 5'd5, 5'd5, 1'b1);
    expect_out("t1_raw", pk(2'b10, 2'b00, 2'b00, 0, 0, 0));

    // 2: writeback of x5 from pipe 0
    step(); wb_valid = 2'b01; wb_dst = {5'd0, 5'd5};
`ifdef IX_SB_BYPASS_EN
    expect_out("t2_wb_cycle", pk(2'b11, 2'b01, 2'b00, 1, 0, 0));
`else
    expect_out("t2_wb_cycle", pk(2'b10, 2'b00, 2'b00, 0, 0, 0));
`endif
    step(); clr();
    expect_out("t2_after", pk(2'b11, 2'b00, 2'b00, 1, 1, 0));

    // 3: tag-mismatched writeback sets sticky err
    step(); iss(5'd7, SB_PIPE_LSP); chk(5'd0, 5'd0, 5'd0, 1'b0);
    step(); clr(); chk(5'd0, 5'd7, 5'd0, 1'b0);
    expect_out("t3_pend", pk(2'b10, 2'b00, 2'b00, 1, 0, 0));
    step(); wb_valid = 2'b01; wb_dst = {5'd0, 5'd7};
    expect_out("t3_badwb", pk(2'b10, 2'b00, 2'b00, 1, 0, 0));
    step(); clr();
    expect_out("t3_err", pk(2'b10, 2'b00, 2'b00, 1, 0, 1));
    step(); wb_valid = 2'b10; wb_dst = {5'd7, 5'd0};
`ifdef IX_SB_BYPASS_EN
    expect_out("t3_goodwb", pk(2'b11, 2'b01, 2'b01, 1, 0, 1));
`else
    expect_out("t3_goodwb", pk(2'b10, 2'b00, 2'b00, 1, 0, 1));
`endif
    step(); clr();
    expect_out("t3_clear", pk(2'b11, 2'b00, 2'b00, 1, 1, 1));

    // 4: kill pipe 0 while issuing x9 on pipe 0
    step(); iss(5'd3, SB_PIPE_INT);
    step(); iss(5'd4, SB_PIPE_LSP);
    step(); iss(5'd9, SB_PIPE_INT); kill = 2'b01; chk(5'd4, 5'd3, 5'd0, 1'b0);
    expect_out("t4_pre", pk(2'b00, 2'b00, 2'b00, 1, 0, 1));
    step(); clr(); chk(5'd4, 5'd3, 5'd9, 1'b1);
    expect_out("t4_kill", pk(2'b01, 2'b00, 2'b00, 0, 0, 1));
    step(); chk(5'd3, 5'd9, 5'd0, 1'b0);
    expect_out("t4_x9", pk(2'b10, 2'b00, 2'b00, 1, 0, 1));
    step(); wb_valid = 2'b11; wb_dst = {5'd4, 5'd9};
    step(); clr(); chk(5'd0, 5'd0, 5'd0, 1'b0);
    expect_out("t4_drain", pk(2'b11, 2'b00, 2'b00, 1, 1, 1));

    // 5: x0 is never tracked
    step(); iss(5'd0, SB_PIPE_INT); chk(5'd0, 5'd0, 5'd0, 1'b1);
    expect_out("t5_x0_iss", pk(2'b11, 2'b00, 2'b00, 1, 1, 1));
    step(); clr();
    expect_out("t5_x0_after", pk(2'b11, 2'b00, 2'b00, 1, 1, 1));

    // 6: reset with ten entries pending
    for (int i = 0; i < 10; i++) begin
      step(); iss(5'(10 + i), i % 2);
    end
    step(); clr(); chk(5'd11, 5'd10, 5'd12, 1'b1);
    expect_out("t6_pre", pk(2'b00, 2'b00, 2'b00, 0, 0, 1));
    step(); rst = 1'b1; iss(5'd20, SB_PIPE_INT); wb_valid = 2'b01; wb_dst = {5'd0, 5'd11};
    step(); rst = 1'b0; clr();
    expect_out("t6_rst", pk(2'b11, 2'b00, 2'b00, 1, 1, 0));

    // Same-cycle issue and writeback on one register: issue wins, new tag, no err
    step(); iss(5'd8, SB_PIPE_INT); chk(5'd0, 5'd0, 5'd0, 1'b0);
    step(); clr(); iss(5'd8, SB_PIPE_LSP); wb_valid = 2'b01; wb_dst = {5'd0, 5'd8};
    chk(5'd8, 5'd0, 5'd0, 1'b0);
`ifdef IX_SB_BYPASS_EN
    expect_out("iss_wb_cycle", pk(2'b11, 2'b10, 2'b00, 1, 0, 0));
`else
    expect_out("iss_wb_cycle", pk(2'b01, 2'b00, 2'b00, 1, 0, 0));
`endif
    step(); clr();
    expect_out("iss_wb_same", pk(2'b01, 2'b00, 2'b00, 1, 0, 0));
    step(); wb_valid = 2'b10; wb_dst = {5'd8, 5'd0};
    step(); clr();
    expect_out("iss_wb_clear", pk(2'b11, 2'b00, 2'b00, 1, 1, 0));

    // Kill takes priority over a writeback from the same pipe without raising err
    step(); iss(5'd6, SB_PIPE_INT); chk(5'd0, 5'd0, 5'd0, 1'b0);
    step(); clr(); kill = 2'b01; wb_valid = 2'b01; wb_dst = {5'd0, 5'd6};
    step(); clr(); chk(5'd0, 5'd6, 5'd0, 1'b0);
    expect_out("kill_prio", pk(2'b11, 2'b00, 2'b00, 1, 1, 0));

    // Issue to a pending register overwrites the tag and sets err
    step(); iss(5'd12, SB_PIPE_INT); chk(5'd0, 5'd12, 5'd0, 1'b0);
    step(); iss(5'd12, SB_PIPE_LSP);
    step(); clr();
    expect_out("overwrite_err", pk(2'b10, 2'b00, 2'b00, 1, 0, 1));
    step(); wb_valid = 2'b10; wb_dst = {5'd12, 5'd0};
    step(); clr();
    expect_out("overwrite_clear", pk(2'b11, 2'b00, 2'b00, 1, 1, 1));

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
